// File: rtl/mc6809e_clkgen.sv
// MC6809E bus-phase generator: quadrature E/Q from CLK_ROOT, single-cycle edge
// enables for the core and peripherals, MRDY stretching and an E-aligned CPU reset.
module mc6809e_clkgen #(
    parameter int DIV            = 16,
    parameter int RESET_E_CYCLES = 8,
    parameter int MAX_STRETCH    = 40
) (
    input  logic CLK_ROOT,
    input  logic nRESET,
    input  logic MRDY,
    output logic E,
    output logic Q,
    output logic CE_Q_RISE,
    output logic CE_E_RISE,
    output logic CE_Q_FALL,
    output logic CE_E_FALL,
    output logic STRETCHING,
    output logic CPU_nRESET
);

    localparam int Q4 = DIV / 4;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(MAX_STRETCH + 2);
    localparam int RW = $clog2(RESET_E_CYCLES + 1);

    logic [1:0]    sync;
    logic          run;
    logic          released;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stretch_cnt;
    logic [RW-1:0] efall_cnt;
    logic          at_end;
    logic          hold;
    logic          ce_q_rise;
    logic          ce_e_rise;
    logic          ce_q_fall;
    logic          ce_e_fall;
    logic          e_level;
    logic          q_level;
    logic          cpu_nreset;

    // Async assert, sync deassert. The counter is allowed to advance on the
    // edge at which the second stage captures the release, so the first count
    // lands on the 2nd edge after nRESET rises.
    always_ff @(posedge CLK_ROOT or negedge nRESET) begin
        if (!nRESET) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign run      = sync[0];
    assign released = sync[1];

    always_comb begin
        at_end    = (cnt == CW'(DIV - 1));
        hold      = run && at_end && !MRDY && (MAX_STRETCH > 0)
                    && (stretch_cnt < SW'(MAX_STRETCH));
        ce_q_rise = run && (cnt == CW'(Q4 - 1));
        ce_e_rise = run && (cnt == CW'(2 * Q4 - 1));
        ce_q_fall = run && (cnt == CW'(3 * Q4 - 1));
        ce_e_fall = run && at_end && !hold;
    end

    // Phase counter and stretch bookkeeping; cnt parks on DIV-1 while held.
    always_ff @(posedge CLK_ROOT or negedge nRESET) begin
        if (!nRESET) begin
            cnt         <= '0;
            stretch_cnt <= '0;
        end else begin
            if (run && !hold) begin
                cnt <= at_end ? '0 : cnt + CW'(1);
            end
            if (hold) begin
                stretch_cnt <= stretch_cnt + SW'(1);
            end else if (ce_e_fall) begin
                stretch_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK_ROOT or negedge nRESET) begin
        if (!nRESET) begin
            e_level <= 1'b0;
            q_level <= 1'b0;
        end else begin
            if (ce_e_rise) begin
                e_level <= 1'b1;
            end else if (ce_e_fall) begin
                e_level <= 1'b0;
            end
            if (ce_q_rise) begin
                q_level <= 1'b1;
            end else if (ce_q_fall) begin
                q_level <= 1'b0;
            end
        end
    end

    // CPU reset lifts on the same edge as the RESET_E_CYCLES-th E fall.
    always_ff @(posedge CLK_ROOT or negedge nRESET) begin
        if (!nRESET) begin
            efall_cnt  <= '0;
            cpu_nreset <= 1'b0;
        end else if (ce_e_fall && released && (efall_cnt != RW'(RESET_E_CYCLES))) begin
            efall_cnt <= efall_cnt + RW'(1);
            if (efall_cnt == RW'(RESET_E_CYCLES - 1)) begin
                cpu_nreset <= 1'b1;
            end
        end
    end

    assign E          = e_level;
    assign Q          = q_level;
    assign CE_Q_RISE  = ce_q_rise;
    assign CE_E_RISE  = ce_e_rise;
    assign CE_Q_FALL  = ce_q_fall;
    assign CE_E_FALL  = ce_e_fall;
    assign STRETCHING = hold;
    assign CPU_nRESET = cpu_nreset;

endmodule

// File: tb/tb_mc6809e_clkgen.sv
// Randomised scoreboard bench for mc6809e_clkgen: four configurations share clock
// and reset; a quarter-arithmetic reference model predicts every cycle's outputs.
module tb_mc6809e_clkgen;

    localparam int N = 4;
    localparam int DIVS [N] = '{8, 8, 8, 16};
    localparam int RSTS [N] = '{3, 3, 3, 8};
    localparam int MAXS [N] = '{40, 4, 0, 40};

    typedef struct packed {
        int                cyc;
        logic [N-1:0][7:0] o;
    } exp_t;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [N-1:0] mrdy = '1;
    wire  [7:0]   obs [N];

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: position in the E period, extra held cycles,
    // edges seen since release and E falls seen since release.
    int phase [N];
    int held  [N];
    int rel   [N];
    int falls [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mc6809e_clkgen #(
            .DIV(DIVS[g]),
            .RESET_E_CYCLES(RSTS[g]),
            .MAX_STRETCH(MAXS[g])
        ) u_dut (
            .CLK_ROOT(clk),
            .nRESET(nreset),
            .MRDY(mrdy[g]),
            .E(obs[g][7]),
            .Q(obs[g][6]),
            .CE_Q_RISE(obs[g][5]),
            .CE_E_RISE(obs[g][4]),
            .CE_Q_FALL(obs[g][3]),
            .CE_E_FALL(obs[g][2]),
            .STRETCHING(obs[g][1]),
            .CPU_nRESET(obs[g][0])
        );
    end

    // Outputs ordered E,Q,CE_Q_RISE,CE_E_RISE,CE_Q_FALL,CE_E_FALL,STRETCHING,CPU_nRESET
    function automatic logic [7:0] model_out(int i, bit nr, bit m);
        logic [7:0] r;
        int  q4      = DIVS[i] / 4;
        int  quarter = phase[i] / q4;
        bit  run     = nr && (rel[i] >= 1);
        bit  at_end  = (phase[i] == DIVS[i] - 1);
        bit  hold    = run && at_end && !m && (held[i] < MAXS[i]);
        r = '0;
        if (nr) begin
            r[7] = (quarter >= 2);
            r[6] = (quarter == 1) || (quarter == 2);
            r[5] = run && (phase[i] == q4 - 1);
            r[4] = run && (phase[i] == 2 * q4 - 1);
            r[3] = run && (phase[i] == 3 * q4 - 1);
            r[2] = run && at_end && !hold;
            r[1] = hold;
            r[0] = (falls[i] >= RSTS[i]);
        end
        return r;
    endfunction

    task automatic model_step(int i, bit nr, bit m);
        bit hold;
        if (!nr) begin
            phase[i] = 0;
            held[i]  = 0;
            rel[i]   = 0;
            falls[i] = 0;
        end else begin
            if (rel[i] >= 1) begin
                hold = (phase[i] == DIVS[i] - 1) && !m && (held[i] < MAXS[i]);
                if (hold) begin
                    held[i]++;
                end else begin
                    if (phase[i] == DIVS[i] - 1) begin
                        held[i] = 0;
                        falls[i]++;
                    end
                    phase[i] = (phase[i] + 1) % DIVS[i];
                end
            end
            if (rel[i] < 2) rel[i]++;
        end
    endtask

    // Drive one cycle's inputs shortly after the edge and queue the prediction.
    task automatic drive_cycle(bit nr, logic [N-1:0] m);
        exp_t e;
        @(posedge clk);
        #2;
        cycle++;
        nreset = nr;
        mrdy   = m;
        e.cyc  = cycle;
        for (int i = 0; i < N; i++) e.o[i] = model_out(i, nr, m[i]);
        sbq.push_back(e);
        for (int i = 0; i < N; i++) model_step(i, nr, m[i]);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #6;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (obs[i] !== e.o[i]) begin
                        errors++;
                        $display("FAIL outputs dut%0d cycle %0d: got %b required %b (E Q QR ER QF EF ST CR)",
                                 i, e.cyc, obs[i], e.o[i]);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [N-1:0] m;
        int           mode;
        int           len;
        int           rst_left;
        int           rst_at;
        for (int i = 0; i < N; i++) begin
            phase[i] = 0;
            held[i]  = 0;
            rel[i]   = 0;
            falls[i] = 0;
        end
        m        = '1;
        rst_left = 0;
        repeat (3) drive_cycle(1'b0, m);
        for (int seg = 0; seg < 40; seg++) begin
            mode   = (seg == 0) ? 0 : $urandom_range(0, 3);
            len    = (seg == 0) ? 100 : $urandom_range(20, 120);
            rst_at = (seg % 6 == 5) ? $urandom_range(5, len - 1) : -1;
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < N; i++) begin
                    case (mode)
                        0:       m[i] = 1'b1;
                        1:       m[i] = ($urandom_range(0, 9) >= 3);
                        2:       m[i] = 1'b0;
                        default: if ($urandom_range(0, 5) == 0) m[i] = ~m[i];
                    endcase
                end
                if (rst_left == 0 && (c == rst_at || $urandom_range(0, 399) == 0))
                    rst_left = $urandom_range(1, 4);
                if (rst_left > 0) begin
                    rst_left--;
                    drive_cycle(1'b0, m);
                end else begin
                    drive_cycle(1'b1, m);
                end
            end
        end
        repeat (3) @(posedge clk);
        #8;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc6809e_clkgen.md
Name: mc6809e_clkgen

Overview:
Clock-phase generator that sits directly upstream of the MC6809E pin-level core wrapper.
- Divides CLK_ROOT into quadrature E/Q bus phases.
- Emits the single-cycle clock enables that the core consumes: CE_E_FALL and CE_Q_FALL, plus rise enables for peripherals.
- Supports MRDY-style E stretching for slow memory.
- Produces a stretched, E-aligned CPU reset.

Parameters:
DIV, 16, CLK_ROOT cycles per E period; multiple of 4, minimum 4; Q4 = DIV/4 cycles per quarter.
RESET_E_CYCLES, 8, number of E falls CPU_nRESET is held low after reset release; minimum 1.
MAX_STRETCH, 40, maximum CLK_ROOT cycles E may be held high by MRDY per bus cycle; 0 disables stretching.

Ports:
CLK_ROOT  input  1  system root clock; all state on its rising edge.
nRESET  input  1  asynchronous active-low reset.
MRDY  input  1  memory ready; low requests E stretch.
E  output  1  registered E phase level.
Q  output  1  registered Q phase level (leads E by one quarter).
CE_Q_RISE  output  1  one-cycle enable; Q rises on the next edge.
CE_E_RISE  output  1  one-cycle enable; E rises on the next edge.
CE_Q_FALL  output  1  one-cycle enable; Q falls on the next edge (feeds core CE_Q_FALL).
CE_E_FALL  output  1  one-cycle enable; E falls on the next edge (feeds core CE_E_FALL).
STRETCHING  output  1  high while E is being held by MRDY.
CPU_nRESET  output  1  active-low reset to the CPU core, E-aligned.

Behaviour:
- Reset (nRESET low, asynchronous):
  - cnt=0, E=0, Q=0.
  - All CE_* = 0, STRETCHING=0, CPU_nRESET=0.
  - Stretch counter and reset counter cleared.
  - Reset mid-cycle or mid-stretch aborts immediately; no partial pulses.
- Release synchronisation:
  - nRESET deassertion passes through a 2-flop synchroniser (async assert, sync deassert).
  - Phase counter holds at 0 until the synchronised reset is high.
  - First counting edge is the 2nd CLK_ROOT rising edge after nRESET rises.
- Phase counter cnt runs 0..DIV-1, increments each cycle and wraps to 0.
- Quarters are indexed by cnt/Q4:
  - Quarter 0: E=0, Q=0.
  - Quarter 1: E=0, Q=1.
  - Quarter 2: E=1, Q=1.
  - Quarter 3: E=1, Q=0.
- E and Q are registered. Each changes on the same edge at which its enable is sampled high.
- Enables are combinational decodes of cnt, one cycle wide:
  - CE_Q_RISE at cnt=Q4-1.
  - CE_E_RISE at cnt=2*Q4-1.
  - CE_Q_FALL at cnt=3*Q4-1.
  - CE_E_FALL at cnt=DIV-1, but only when not stretching.
  - Never more than one enable high in any cycle; all enables low while the synchronised reset is low.
- Stretch:
  - Condition: cnt=DIV-1 with MRDY=0, MAX_STRETCH>0 and stretch count < MAX_STRETCH.
  - Effect: cnt holds, E stays 1, Q stays 0, CE_E_FALL suppressed, STRETCHING=1, stretch count increments.
  - MRDY is sampled every held cycle.
  - When MRDY=1, or when stretch count reaches MAX_STRETCH, CE_E_FALL asserts that cycle and cnt wraps on the next edge.
  - Stretch count clears at wrap.
  - MRDY is ignored at all other cnt values.
- CPU reset:
  - A saturating counter counts CE_E_FALL pulses after release.
  - CPU_nRESET rises on the edge at which the RESET_E_CYCLES-th CE_E_FALL is sampled, so the core leaves reset on an E fall.
  - It then stays 1 until nRESET goes low again.
- Enables run throughout CPU reset, so the core sees clocking while held in reset.

Test Plan:
1. DIV=8, MRDY=1, release nRESET:
   - Counting starts on the 2nd edge after release.
   - CE_Q_RISE, CE_E_RISE, CE_Q_FALL, CE_E_FALL seen at cnt=1, 3, 5, 7, each one cycle wide.
   - E/Q follow 00→01→11→10 with 2-cycle quarters; E period exactly 8 cycles over 10 periods.
2. DIV=8, RESET_E_CYCLES=3:
   - CPU_nRESET is 0 through the first two CE_E_FALLs.
   - It rises on the edge sampling the 3rd CE_E_FALL, coincident with E falling, and stays 1.
3. DIV=8, MAX_STRETCH=40, MRDY=0 for 5 cycles from cnt=7:
   - E held high for 5 extra cycles; STRETCHING=1 for exactly those 5 cycles.
   - A single CE_E_FALL follows once MRDY=1; next period is normal 8 cycles.
4. MAX_STRETCH=4, MRDY held 0:
   - Stretch ends after 4 extra cycles, then forced CE_E_FALL.
   - Every subsequent period is 12 cycles while MRDY stays 0.
5. MAX_STRETCH=0, MRDY=0: no stretch, 8-cycle period, STRETCHING never asserts.
6. Assert nRESET low mid-quarter 2 and mid-stretch:
   - E, Q, CE_*, STRETCHING and CPU_nRESET drop to 0 immediately, without a clock edge.
   - After release, the sequence restarts from cnt=0 and the CPU_nRESET count restarts from zero.
